// File: rtl/uparc_lsu.sv
// Load/store unit: turns one-cycle memory-stage commands into a single req/ack
// data-bus transfer with lane steering, alignment checks and a bus watchdog.
module uparc_lsu #(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [1:0]  lsu_cmd,
  input  logic        lsu_rnw,
  output logic [31:0] lsu_rdata,
  output logic        lsu_busy,
  output logic        lsu_err_align,
  output logic        lsu_err_bus,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_ben,
  output logic        o_bus_rnw,
  output logic        o_bus_req,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_bus_ack,
  input  logic        i_bus_err
);

  localparam int unsigned CW = (BUS_TIMEOUT > 0) ? $clog2(BUS_TIMEOUT + 1) : 1;

  localparam logic [1:0] CmdIdle  = 2'b00;
  localparam logic [1:0] CmdByte  = 2'b01;
  localparam logic [1:0] CmdHword = 2'b10;
  localparam logic [1:0] CmdWord  = 2'b11;

  typedef enum logic {StIdle, StBus} state_e;

  state_e        state_q;
  logic [31:0]   addr_q, wdata_q, rdata_q;
  logic [3:0]    ben_q;
  logic          rnw_q, req_q, err_bus_q;
  logic [1:0]    off_q, size_q;
  logic [CW-1:0] cnt_q;

  logic        aligned, start, wdog_hit, fail;
  logic [3:0]  ben_nxt;
  logic [31:0] wdata_nxt, shifted, load_data;

  always_comb begin
    aligned   = 1'b1;
    ben_nxt   = 4'b1111;
    wdata_nxt = lsu_wdata;
    unique case (lsu_cmd)
      CmdByte: begin
        ben_nxt   = 4'b0001 << lsu_addr[1:0];
        wdata_nxt = {4{lsu_wdata[7:0]}};
      end
      CmdHword: begin
        aligned   = ~lsu_addr[0];
        ben_nxt   = 4'b0011 << lsu_addr[1:0];
        wdata_nxt = {2{lsu_wdata[15:0]}};
      end
      CmdWord:  aligned = (lsu_addr[1:0] == 2'b00);
      default:  aligned = 1'b1;
    endcase
  end

  assign start         = (state_q == StIdle) && (lsu_cmd != CmdIdle) && aligned;
  assign lsu_err_align = (state_q == StIdle) && (lsu_cmd != CmdIdle) && !aligned;
  assign lsu_busy      = start || (state_q == StBus);

  // Watchdog fires on the BUS_TIMEOUT-th BUS cycle without a response.
  assign wdog_hit = (BUS_TIMEOUT != 0) &&
                    ({{(32 - CW){1'b0}}, cnt_q} == BUS_TIMEOUT - 1);
  assign fail     = i_bus_err || wdog_hit;

  always_comb begin
    shifted = i_bus_rdata >> {off_q, 3'b000};
    unique case (size_q)
      CmdByte:  load_data = {24'h0, shifted[7:0]};
      CmdHword: load_data = {16'h0, shifted[15:0]};
      default:  load_data = i_bus_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      ben_q     <= '0;
      rnw_q     <= 1'b0;
      req_q     <= 1'b0;
      err_bus_q <= 1'b0;
      off_q     <= '0;
      size_q    <= '0;
      cnt_q     <= '0;
    end else begin
      err_bus_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StBus;
            req_q   <= 1'b1;
            addr_q  <= {lsu_addr[31:2], 2'b00};
            wdata_q <= wdata_nxt;
            ben_q   <= ben_nxt;
            rnw_q   <= lsu_rnw;
            off_q   <= lsu_addr[1:0];
            size_q  <= lsu_cmd;
            cnt_q   <= '0;
          end
        end
        StBus: begin
          if (fail) begin
            state_q   <= StIdle;
            req_q     <= 1'b0;
            err_bus_q <= 1'b1;
            if (rnw_q) rdata_q <= '0;
          end else if (i_bus_ack) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            if (rnw_q) rdata_q <= load_data;
          end
          if (!fail && !i_bus_ack && (cnt_q != {CW{1'b1}})) cnt_q <= cnt_q + 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign lsu_rdata   = rdata_q;
  assign lsu_err_bus = err_bus_q;
  assign o_bus_addr  = addr_q;
  assign o_bus_wdata = wdata_q;
  assign o_bus_ben   = ben_q;
  assign o_bus_rnw   = rnw_q;
  assign o_bus_req   = req_q;

endmodule

// File: tb/tb_uparc_lsu.sv
// Directed bench for uparc_lsu with a small watchdog so timeouts stay short.
module tb_uparc_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [1:0]  lsu_cmd;
  logic        lsu_rnw, lsu_busy, lsu_err_align, lsu_err_bus;
  logic [31:0] o_bus_addr, o_bus_wdata, i_bus_rdata;
  logic [3:0]  o_bus_ben;
  logic        o_bus_rnw, o_bus_req, i_bus_ack, i_bus_err;

  int total = 0;
  int bad   = 0;

  // Captured on the first request cycle of each transfer.
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_ben;
  logic        cap_rnw;
  int          busy_n, req_n;
  bit          done;

  uparc_lsu #(.BUS_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_cmd(lsu_cmd),
    .lsu_rnw(lsu_rnw), .lsu_rdata(lsu_rdata), .lsu_busy(lsu_busy),
    .lsu_err_align(lsu_err_align), .lsu_err_bus(lsu_err_bus), .o_bus_addr(o_bus_addr),
    .o_bus_wdata(o_bus_wdata), .o_bus_ben(o_bus_ben), .o_bus_rnw(o_bus_rnw),
    .o_bus_req(o_bus_req), .i_bus_rdata(i_bus_rdata), .i_bus_ack(i_bus_ack),
    .i_bus_err(i_bus_err)
  );

  always #5 clk = ~clk;

  // Issue a one-cycle command, then act as the bus slave: respond on the
  // resp_after-th request cycle (0 = never) with ack, err or both.
  task automatic run_cmd(input logic [1:0] cmd, input logic rnw, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd, input int resp_after,
                         input logic do_ack, input logic do_err);
    @(negedge clk);
    lsu_cmd = cmd; lsu_rnw = rnw; lsu_addr = addr; lsu_wdata = wd; i_bus_rdata = rd;
    #1;
    busy_n = lsu_busy ? 1 : 0;
    req_n  = 0;
    done   = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(posedge clk); #1;
      lsu_cmd = 2'b00; i_bus_ack = 1'b0; i_bus_err = 1'b0;
      if (!lsu_busy) begin
        done = 1;
      end else begin
        busy_n++;
        if (o_bus_req) begin
          req_n++;
          if (req_n == 1) begin
            cap_addr = o_bus_addr; cap_wdata = o_bus_wdata;
            cap_ben = o_bus_ben; cap_rnw = o_bus_rnw;
          end
          if (resp_after != 0 && req_n == resp_after) begin
            i_bus_ack = do_ack; i_bus_err = do_err;
          end
        end
      end
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL run_cmd_timeout: busy still high after 30 cycles, required idle");
    end
  endtask

  task automatic test_reset();
    total++;
    if (o_bus_req !== 1'b0 || lsu_rdata !== 32'h0 || lsu_busy !== 1'b0 ||
        lsu_err_bus !== 1'b0 || o_bus_ben !== 4'h0 || o_bus_addr !== 32'h0) begin
      bad++;
      $display("FAIL reset: req=%b rdata=%h busy=%b errb=%b ben=%b addr=%h, required all 0",
               o_bus_req, lsu_rdata, lsu_busy, lsu_err_bus, o_bus_ben, o_bus_addr);
    end
  endtask

  task automatic test_lw();
    run_cmd(2'b11, 1'b1, 32'h100, 32'h0, 32'hDEADBEEF, 3, 1'b1, 1'b0);
    total++;
    if (req_n !== 3 || busy_n !== 4) begin
      bad++;
      $display("FAIL lw_timing: req=%0d busy=%0d, required req=3 busy=4", req_n, busy_n);
    end
    total++;
    if (cap_addr !== 32'h100 || cap_ben !== 4'b1111 || cap_rnw !== 1'b1) begin
      bad++;
      $display("FAIL lw_bus: addr=%h ben=%b rnw=%b, required 00000100 1111 1",
               cap_addr, cap_ben, cap_rnw);
    end
    total++;
    if (lsu_rdata !== 32'hDEADBEEF || lsu_err_bus !== 1'b0) begin
      bad++;
      $display("FAIL lw_rdata: rdata=%h errb=%b, required deadbeef 0", lsu_rdata, lsu_err_bus);
    end
  endtask

  task automatic test_lb_lh();
    run_cmd(2'b01, 1'b1, 32'h203, 32'h0, 32'h80112233, 1, 1'b1, 1'b0);
    total++;
    if (cap_addr !== 32'h200 || cap_ben !== 4'b1000 || lsu_rdata !== 32'h00000080) begin
      bad++;
      $display("FAIL lb: addr=%h ben=%b rdata=%h, required 00000200 1000 00000080",
               cap_addr, cap_ben, lsu_rdata);
    end
    run_cmd(2'b10, 1'b1, 32'h102, 32'h0, 32'hA1B2C3D4, 2, 1'b1, 1'b0);
    total++;
    if (cap_addr !== 32'h100 || cap_ben !== 4'b1100 || lsu_rdata !== 32'h0000A1B2) begin
      bad++;
      $display("FAIL lh: addr=%h ben=%b rdata=%h, required 00000100 1100 0000a1b2",
               cap_addr, cap_ben, lsu_rdata);
    end
    run_cmd(2'b01, 1'b1, 32'h301, 32'h0, 32'h44332211, 1, 1'b1, 1'b0);
    total++;
    if (cap_ben !== 4'b0010 || lsu_rdata !== 32'h00000022) begin
      bad++;
      $display("FAIL lb_lane1: ben=%b rdata=%h, required 0010 00000022", cap_ben, lsu_rdata);
    end
  endtask

  task automatic test_stores();
    run_cmd(2'b10, 1'b0, 32'h10A, 32'h0000ABCD, 32'h12345678, 1, 1'b1, 1'b0);
    total++;
    if (cap_ben !== 4'b1100 || cap_wdata !== 32'hABCDABCD || cap_rnw !== 1'b0 ||
        cap_addr !== 32'h108) begin
      bad++;
      $display("FAIL sh: ben=%b wdata=%h rnw=%b addr=%h, required 1100 abcdabcd 0 00000108",
               cap_ben, cap_wdata, cap_rnw, cap_addr);
    end
    total++;
    if (lsu_rdata !== 32'h00000022) begin
      bad++;
      $display("FAIL sh_rdata_kept: rdata=%h, required 00000022", lsu_rdata);
    end
    run_cmd(2'b01, 1'b0, 32'h101, 32'hFFFFFF5A, 32'h0, 1, 1'b1, 1'b0);
    total++;
    if (cap_ben !== 4'b0010 || cap_wdata !== 32'h5A5A5A5A) begin
      bad++;
      $display("FAIL sb: ben=%b wdata=%h, required 0010 5a5a5a5a", cap_ben, cap_wdata);
    end
  endtask

  task automatic test_align();
    @(negedge clk);
    lsu_cmd = 2'b11; lsu_rnw = 1'b1; lsu_addr = 32'h102;
    #1;
    total++;
    if (lsu_err_align !== 1'b1 || lsu_busy !== 1'b0) begin
      bad++;
      $display("FAIL align_lw: err_align=%b busy=%b, required 1 0", lsu_err_align, lsu_busy);
    end
    @(posedge clk); #1;
    lsu_cmd = 2'b00;
    #1;
    total++;
    if (o_bus_req !== 1'b0 || lsu_err_align !== 1'b0 || lsu_rdata !== 32'h00000022) begin
      bad++;
      $display("FAIL align_after: req=%b err_align=%b rdata=%h, required 0 0 00000022",
               o_bus_req, lsu_err_align, lsu_rdata);
    end
    @(negedge clk);
    lsu_cmd = 2'b10; lsu_addr = 32'h203;
    #1;
    total++;
    if (lsu_err_align !== 1'b1 || lsu_busy !== 1'b0) begin
      bad++;
      $display("FAIL align_lh: err_align=%b busy=%b, required 1 0", lsu_err_align, lsu_busy);
    end
    lsu_cmd = 2'b00;
  endtask

  task automatic test_bus_errors();
    run_cmd(2'b11, 1'b1, 32'h400, 32'h0, 32'hCAFEF00D, 0, 1'b0, 1'b0);
    total++;
    if (req_n !== 4 || lsu_err_bus !== 1'b1 || lsu_rdata !== 32'h0 || lsu_busy !== 1'b0) begin
      bad++;
      $display("FAIL timeout: req=%0d errb=%b rdata=%h busy=%b, required 4 1 00000000 0",
               req_n, lsu_err_bus, lsu_rdata, lsu_busy);
    end
    @(posedge clk); #1;
    total++;
    if (lsu_err_bus !== 1'b0) begin
      bad++;
      $display("FAIL err_pulse: errb=%b, required 0", lsu_err_bus);
    end
    run_cmd(2'b11, 1'b1, 32'h500, 32'h0, 32'h11111111, 1, 1'b1, 1'b0);
    // ack and err together: err wins, rdata cleared.
    run_cmd(2'b11, 1'b1, 32'h504, 32'h0, 32'h22222222, 2, 1'b1, 1'b1);
    total++;
    if (req_n !== 2 || lsu_err_bus !== 1'b1 || lsu_rdata !== 32'h0) begin
      bad++;
      $display("FAIL ack_err: req=%0d errb=%b rdata=%h, required 2 1 00000000",
               req_n, lsu_err_bus, lsu_rdata);
    end
    // Store error leaves rdata alone.
    run_cmd(2'b11, 1'b1, 32'h508, 32'h0, 32'h33333333, 1, 1'b1, 1'b0);
    run_cmd(2'b11, 1'b0, 32'h50C, 32'h0, 32'h0, 1, 1'b0, 1'b1);
    total++;
    if (lsu_err_bus !== 1'b1 || lsu_rdata !== 32'h33333333) begin
      bad++;
      $display("FAIL st_err: errb=%b rdata=%h, required 1 33333333", lsu_err_bus, lsu_rdata);
    end
    // ack in IDLE must be ignored.
    @(negedge clk);
    i_bus_ack = 1'b1; i_bus_rdata = 32'h99999999;
    @(posedge clk); #1;
    i_bus_ack = 1'b0;
    total++;
    if (lsu_rdata !== 32'h33333333 || o_bus_req !== 1'b0 || lsu_busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_ack: rdata=%h req=%b busy=%b, required 33333333 0 0",
               lsu_rdata, o_bus_req, lsu_busy);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    lsu_cmd = 2'b11; lsu_rnw = 1'b1; lsu_addr = 32'h600;
    @(posedge clk); #1;
    lsu_cmd = 2'b00;
    total++;
    if (o_bus_req !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_pre: req=%b, required 1", o_bus_req);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if (o_bus_req !== 1'b0 || lsu_busy !== 1'b0 || lsu_rdata !== 32'h0) begin
      bad++;
      $display("FAIL rst_mid: req=%b busy=%b rdata=%h, required 0 0 00000000",
               o_bus_req, lsu_busy, lsu_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    run_cmd(2'b10, 1'b1, 32'h700, 32'h0, 32'h0000BEEF, 1, 1'b1, 1'b0);
    total++;
    if (req_n !== 1 || busy_n !== 2 || lsu_rdata !== 32'h0000BEEF) begin
      bad++;
      $display("FAIL rst_recover: req=%0d busy=%0d rdata=%h, required 1 2 0000beef",
               req_n, busy_n, lsu_rdata);
    end
  endtask

  initial begin
    rst = 1'b1;
    lsu_addr = '0; lsu_wdata = '0; lsu_cmd = 2'b00; lsu_rnw = 1'b0;
    i_bus_rdata = '0; i_bus_ack = 1'b0; i_bus_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_lw();
    test_lb_lh();
    test_stores();
    test_align();
    test_bus_errors();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
